// File: rtl/com_ctrl_pkg.sv
// Shared definitions for the serial-port MMIO controller: register offsets,
// STATUS bit positions and the transmit sequencer state encoding.
package com_ctrl_pkg;

  localparam logic COM_REG_DATA = 1'b0;
  localparam logic COM_REG_STAT = 1'b1;

  localparam int STAT_RX_AVAIL = 0;
  localparam int STAT_TX_RDY   = 1;
  localparam int STAT_RX_OVF   = 2;
  localparam int STAT_TX_DROP  = 3;
  localparam int STAT_RX_IE    = 4;
  localparam int STAT_TX_IE    = 5;
  localparam int STAT_W        = 6;

  typedef enum logic [1:0] {
    TX_IDLE    = 2'd0,
    TX_START   = 2'd1,
    TX_WAIT_HI = 2'd2,
    TX_WAIT_LO = 2'd3
  } tx_state_e;

  function automatic logic [STAT_W-1:0] pack_status(
    input logic rx_avail, input logic tx_rdy, input logic rx_ovf,
    input logic tx_drop, input logic rx_ie, input logic tx_ie);
    logic [STAT_W-1:0] s;
    s                = '0;
    s[STAT_RX_AVAIL] = rx_avail;
    s[STAT_TX_RDY]   = tx_rdy;
    s[STAT_RX_OVF]   = rx_ovf;
    s[STAT_TX_DROP]  = tx_drop;
    s[STAT_RX_IE]    = rx_ie;
    s[STAT_TX_IE]    = tx_ie;
    return s;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous 8-bit FIFO. A push while full is discarded unless a pop happens
// in the same cycle; a pop while empty is ignored.
module byte_fifo #(
  parameter int FIFO_AW = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               push_ok, pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == (FIFO_AW+1)'(DEPTH));
  assign dout  = mem[rd_ptr_q];

  always_comb begin
    pop_ok   = pop & ~empty;
    // At full, a concurrent pop frees the slot the push lands in.
    push_ok  = push & (~full | pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    count_d  = count_q + (FIFO_AW+1)'(push_ok) - (FIFO_AW+1)'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/com_mmio_ctrl.sv
// CPU-facing serial-port controller: RX byte FIFO, single-byte transmit
// sequencer, DATA/STATUS registers and a level interrupt.
module com_mmio_ctrl
  import com_ctrl_pkg::*;
#(
  parameter int FIFO_AW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_addr,
  input  logic        bus_rd,
  input  logic        bus_wr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        irq
);

  logic        rx_ready_q;
  logic        rx_push_q, rx_push_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic [31:0] bus_rdata_q, bus_rdata_d;
  logic        rx_ovf_q, rx_ovf_d;
  logic        tx_drop_q, tx_drop_d;
  logic        rx_ie_q, rx_ie_d;
  logic        tx_ie_q, tx_ie_d;
  logic        irq_q, irq_d;
  tx_state_e   state_q;
  logic        tx_start_q;
  logic [7:0]  tx_data_q;

  logic              data_rd, stat_rd, data_wr, ctrl_wr;
  logic              tx_idle, fifo_pop, fifo_empty, fifo_full;
  logic [7:0]        fifo_dout;
  logic [STAT_W-1:0] status;
  logic              unused_wdata;

  assign unused_wdata = ^bus_wdata[31:8];

  byte_fifo #(.FIFO_AW(FIFO_AW)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push_q),
    .pop   (fifo_pop),
    .din   (rx_byte_q),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_comb begin
    // A write wins over a simultaneous read; the read is then ignored.
    data_rd  = bus_rd & ~bus_wr & (bus_addr == COM_REG_DATA);
    stat_rd  = bus_rd & ~bus_wr & (bus_addr == COM_REG_STAT);
    data_wr  = bus_wr & (bus_addr == COM_REG_DATA);
    ctrl_wr  = bus_wr & (bus_addr == COM_REG_STAT);
    tx_idle  = (state_q == TX_IDLE);
    fifo_pop = data_rd & ~fifo_empty;

    rx_push_d = rx_ready & ~rx_ready_q;
    rx_byte_d = rx_push_d ? rx_data : rx_byte_q;

    status = pack_status(~fifo_empty, tx_idle, rx_ovf_q, tx_drop_q, rx_ie_q, tx_ie_q);

    bus_rdata_d = bus_rdata_q;
    if (data_rd)      bus_rdata_d = fifo_empty ? 32'h0 : {24'h0, fifo_dout};
    else if (stat_rd) bus_rdata_d = {{(32-STAT_W){1'b0}}, status};

    // New error events take priority over the clear-on-read.
    rx_ovf_d  = (rx_push_q & fifo_full & ~fifo_pop) | (rx_ovf_q & ~stat_rd);
    tx_drop_d = (data_wr & ~tx_idle) | (tx_drop_q & ~stat_rd);
    rx_ie_d   = ctrl_wr ? bus_wdata[STAT_RX_IE] : rx_ie_q;
    tx_ie_d   = ctrl_wr ? bus_wdata[STAT_TX_IE] : tx_ie_q;
    irq_d     = (rx_ie_q & ~fifo_empty) | (tx_ie_q & tx_idle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ready_q  <= 1'b0;
      rx_push_q   <= 1'b0;
      rx_byte_q   <= 8'h0;
      bus_rdata_q <= 32'h0;
      rx_ovf_q    <= 1'b0;
      tx_drop_q   <= 1'b0;
      rx_ie_q     <= 1'b0;
      tx_ie_q     <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      rx_ready_q  <= rx_ready;
      rx_push_q   <= rx_push_d;
      rx_byte_q   <= rx_byte_d;
      bus_rdata_q <= bus_rdata_d;
      rx_ovf_q    <= rx_ovf_d;
      tx_drop_q   <= tx_drop_d;
      rx_ie_q     <= rx_ie_d;
      tx_ie_q     <= tx_ie_d;
      irq_q       <= irq_d;
    end
  end

  // Transmit sequencer: one start pulse, then track the busy pulse of the UART.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= TX_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        TX_IDLE: begin
          if (data_wr) begin
            state_q    <= TX_START;
            tx_start_q <= 1'b1;
            tx_data_q  <= bus_wdata[7:0];
          end
        end
        TX_START:   state_q <= TX_WAIT_HI;
        TX_WAIT_HI: if (tx_busy)  state_q <= TX_WAIT_LO;
        TX_WAIT_LO: if (!tx_busy) state_q <= TX_IDLE;
        default:    state_q <= TX_IDLE;
      endcase
    end
  end

  assign bus_rdata = bus_rdata_q;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign irq       = irq_q;

endmodule

// File: doc/com_mmio_ctrl.md
# com_mmio_ctrl

Memory-mapped serial-port controller between the CPU data bus and the async UART pair (`uart_async_receiver` / `uart_async_transmitter`). It does three things:
- Buffers received bytes in a FIFO.
- Sequences single-byte transmits through a start/busy handshake.
- Exposes data and status words to the CPU and drives a level interrupt line into the CP0 cause IP bits.

## Interface
Parameters:
- `FIFO_AW`, 4: RX FIFO address width. Depth is 2^FIFO_AW (16).

Ports:
- `clk`  in  1: system clock, same clock as the UART pair.
- `rst`  in  1: asynchronous, active-high reset.
- `bus_addr`  in  1: word select. 0 = DATA, 1 = STATUS/CTRL.
- `bus_rd`  in  1: read strobe, one cycle per access.
- `bus_wr`  in  1: write strobe, one cycle per access.
- `bus_wdata`  in  32: write data.
- `bus_rdata`  out  32: registered read data.
- `rx_data`  in  8: receiver byte (`RxD_data`).
- `rx_ready`  in  1: receiver data-ready (`RxD_data_ready`).
- `tx_busy`  in  1: transmitter busy (`TxD_busy`).
- `tx_start`  out  1: transmitter start pulse.
- `tx_data`  out  8: transmitter byte.
- `irq`  out  1: interrupt request, level.

## Operation
- **RX capture:** push `rx_data` on the rising edge of `rx_ready` (registered previous value, edge-detected). A held-high `rx_ready` pushes exactly once.
- **DATA read:**
  - FIFO non-empty: pops, returns `{24'h0, byte}`.
  - FIFO empty: returns 0, no pop, no state change.
- **DATA write:**
  - In TX_IDLE: latches `bus_wdata[7:0]` into `tx_data` and moves to TX_START.
  - Otherwise: the byte is dropped and sticky `tx_drop` is set.
- **STATUS read**, returning `{26'h0, tx_ie, rx_ie, tx_drop, rx_ovf, tx_rdy, rx_avail}` at bits [5:0]:
  - `rx_avail` = FIFO non-empty.
  - `tx_rdy` = TX_IDLE.
  - `rx_ovf`, `tx_drop` = sticky error bits.
  - `rx_ie`, `tx_ie` = interrupt enables.
  - The read clears `rx_ovf` and `tx_drop` after they are sampled into `bus_rdata`.
- **CTRL write:** `bus_wdata[4]` → `rx_ie`, `bus_wdata[5]` → `tx_ie`. Other bits are ignored.
- **Interrupt:** `irq = (rx_ie & rx_avail) | (tx_ie & tx_rdy)`, registered.
- **TX FSM:**
  - TX_IDLE → TX_START on accepted DATA write.
  - TX_START: `tx_start` = 1 for exactly one cycle → TX_WAIT_HI.
  - TX_WAIT_HI: wait `tx_busy` = 1 → TX_WAIT_LO.
  - TX_WAIT_LO: wait `tx_busy` = 0 → TX_IDLE.
- **FIFO full:**
  - Push without a same-cycle pop: the new byte is discarded, `rx_ovf` = 1, and FIFO contents are unchanged.
  - Push with a same-cycle pop: both occur, no overflow.
- **Pointers:** wrap modulo depth. Count width is FIFO_AW+1, so full and empty are distinct.
- **Simultaneous push and pop on an empty FIFO:** the pop returns 0. The pushed byte is stored.
- **Simultaneous `bus_rd` and `bus_wr`:** the write takes effect and `bus_rdata` holds its previous value.

## Timing
- **Reset values:**
  - `bus_rdata` = 0, `tx_start` = 0, `tx_data` = 0, `irq` = 0.
  - FIFO empty; `rx_ovf` = 0, `tx_drop` = 0, `rx_ie` = 0, `tx_ie` = 0; FSM in TX_IDLE.
- **Reset mid-transmit:** the FSM returns to TX_IDLE immediately. Any in-flight UART frame is not tracked.
- **Read latency:** 1 cycle. `bus_rdata` is valid in the cycle after `bus_rd`; the pop and sticky-clear take effect at that same edge.
- **RX latency:** `rx_avail` is 1 two cycles after the `rx_ready` rise (1 cycle edge register, 1 cycle FIFO write).
- **TX latency:**
  - `tx_start` is asserted in the cycle after the accepted write.
  - `tx_rdy` reads 0 from that cycle until the cycle after `tx_busy` falls.
- **irq:** follows its inputs with 1 cycle of latency.

## Structure
- Shared package `com_ctrl_pkg`:
  - Register offsets: `COM_REG_DATA` = 0, `COM_REG_STAT` = 1.
  - STATUS bit indices.
  - TX state encoding: 2 bits, TX_IDLE = 0.
- Sub-module `byte_fifo`:
  - Synchronous FIFO, 8-bit data, parameter FIFO_AW.
  - Ports: push, pop, din, dout, empty, full.
  - Same push/pop-at-full rules as above.
- Top level contains: edge detect, register decode, TX FSM, irq register.

## Test plan
- Reset, then read STATUS → 0x2 (`tx_rdy` only); `irq` = 0.
- Three `rx_ready` pulses with 0x41, 0x42, 0x43; three DATA reads → 0x41, 0x42, 0x43; fourth read → 0; `rx_avail` = 0.
- 17 pushes with no reads → the first 16 bytes are retained. STATUS read → `rx_ovf` = 1; a second STATUS read → `rx_ovf` = 0.
- Write DATA 0xF3 → `tx_start` for one cycle with `tx_data` = 0xF3. A second write while busy is dropped, `tx_drop` = 1, and there is no second `tx_start`. `tx_rdy` returns after `tx_busy` falls.
- Write CTRL 0x10, then push one byte → `irq` rises. A DATA read of that byte → `irq` falls one cycle later.
- Assert `rst` during TX_WAIT_LO → `tx_start` = 0 and `tx_rdy` = 1 immediately; all outputs match reset values.
